// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, request bit
// indices and Status/Cause field positions used by the CP0 slice.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  localparam int REQ_ADEL = 0;
  localparam int REQ_ADES = 1;
  localparam int REQ_SYS  = 2;
  localparam int REQ_BP   = 3;
  localparam int REQ_RI   = 4;
  localparam int REQ_OV   = 5;
  localparam int REQ_TR   = 6;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_IM_HI  = 15;

  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_WP     = 22;
  localparam int CA_IV     = 23;
  localparam int CA_BD     = 31;

  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  localparam logic [31:0] STATUS_WMASK = 32'hF000_FF03;
  localparam logic [31:0] CONFIG_VAL   = 32'h0000_8000;

  // Compare register number of timer k: timer 0 sits at 11, the rest at 22..24.
  function automatic logic [4:0] compare_addr(input int k);
    if (k == 0) return CP0_COMPARE;
    return 5'(21 + k);
  endfunction

endpackage

// File: rtl/cp0_ctrl_param_if.sv
// Pipeline-side CP0 bus: MTC0/MFC0 access, MEM-stage exception inputs and
// the flush/redirect returned to the core.
interface cp0_ctrl_param_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [7:0]  exc_req_i;
  logic        eret_i;
  logic [31:0] exc_pc_i;
  logic        exc_in_ds_i;
  logic [31:0] exc_vaddr_i;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i,
    output exc_req_i, eret_i, exc_pc_i, exc_in_ds_i, exc_vaddr_i,
    input  rdata_o, flush_o, new_pc_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i,
    input  exc_req_i, eret_i, exc_pc_i, exc_in_ds_i, exc_vaddr_i,
    output rdata_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/cp0_timer.sv
// One CP0 compare timer: holds a Compare value and a sticky match flag.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  input  logic [31:0] count,
  output logic [31:0] compare,
  output logic        irq
);

  // Software write reloads Compare and acknowledges the flag; otherwise a match latches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      compare <= '0;
      irq     <= 1'b0;
    end else if (wr_en) begin
      compare <= wdata;
      irq     <= 1'b0;
    end else if ((compare != 32'd0) && (count == compare)) begin
      irq <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_ctrl_param.sv
// MIPS32 coprocessor 0 beside MEM/WB: Count, Status, Cause, EPC, compare
// timers, event prioritisation, ERET and the pipeline flush/redirect.
// Optional feature macro: CP0_BADVADDR_EN adds the read-only BadVAddr (reg 8).
module cp0_ctrl_param
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          NUM_TIMERS = 1,
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  cp0_ctrl_param_if.slave       bus,
  output logic [NUM_TIMERS-1:0] timer_int_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic [31:0] count_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic [31:0] compare_val [NUM_TIMERS];
  logic [31:0] badvaddr_rd;

  logic [7:2]  ip_sample;
  logic        int_pending;
  logic        take;
  exc_code_e   exc_code;
  logic        exl;

  logic wr_count, wr_status, wr_cause, wr_epc;

  assign wr_count  = bus.we_i && (bus.waddr_i == CP0_COUNT);
  assign wr_status = bus.we_i && (bus.waddr_i == CP0_STATUS);
  assign wr_cause  = bus.we_i && (bus.waddr_i == CP0_CAUSE);
  assign wr_epc    = bus.we_i && (bus.waddr_i == CP0_EPC);
  assign exl       = status_q[ST_EXL];

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_timer
    cp0_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.we_i && (bus.waddr_i == compare_addr(k))),
      .wdata   (bus.wdata_i),
      .count   (count_q),
      .compare (compare_val[k]),
      .irq     (timer_int_o[k])
    );
  end

  // Map external lines and timer flags onto the hardware pending bits IP[7:2].
  always_comb begin
    ip_sample = '0;
    for (int j = 0; j < NUM_HW_INT; j++) ip_sample[2+j] = hw_int_i[j];
    for (int k = 0; k < NUM_TIMERS; k++) ip_sample[7-k] = ip_sample[7-k] | timer_int_o[k];
  end

  // A zero MEM PC marks a bubble, so interrupts wait for a real instruction to attach to.
  assign int_pending = status_q[ST_IE] && !exl && (bus.exc_pc_i != 32'd0) &&
                       (|(cause_q[CA_IP_HI:CA_IP_LO] & status_q[ST_IM_HI:ST_IM_LO]));

  // Fixed-priority selection of the single event taken this cycle.
  always_comb begin
    take     = 1'b1;
    exc_code = EXC_INT;
    if (int_pending)                   exc_code = EXC_INT;
    else if (bus.exc_req_i[REQ_ADEL])  exc_code = EXC_ADEL;
    else if (bus.exc_req_i[REQ_ADES])  exc_code = EXC_ADES;
    else if (bus.exc_req_i[REQ_SYS])   exc_code = EXC_SYS;
    else if (bus.exc_req_i[REQ_BP])    exc_code = EXC_BP;
    else if (bus.exc_req_i[REQ_RI])    exc_code = EXC_RI;
    else if (bus.exc_req_i[REQ_OV])    exc_code = EXC_OV;
    else if (bus.exc_req_i[REQ_TR])    exc_code = EXC_TR;
    else                               take     = 1'b0;
  end

  // Free-running Count; a software write replaces the increment.
  always_ff @(posedge clk) begin
    if (rst)           count_q <= '0;
    else if (wr_count) count_q <= bus.wdata_i;
    else               count_q <= count_q + 32'd1;
  end

  // Status: masked MTC0 first, then event/ERET EXL updates override it.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RESET;
    end else begin
      if (wr_status) status_q <= (status_q & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
      if (take)             status_q[ST_EXL] <= 1'b1;
      else if (bus.eret_i)  status_q[ST_EXL] <= 1'b0;
    end
  end

  // Cause: hardware IP resampled each cycle, software bits on MTC0, event fields last.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
    end else begin
      cause_q[CA_IP_HI:CA_IP_LO+2] <= ip_sample;
      if (wr_cause) begin
        cause_q[CA_IV]                 <= bus.wdata_i[CA_IV];
        cause_q[CA_WP]                 <= bus.wdata_i[CA_WP];
        cause_q[CA_IP_LO+1:CA_IP_LO]   <= bus.wdata_i[CA_IP_LO+1:CA_IP_LO];
      end
      if (take) begin
        cause_q[CA_EXC_HI:CA_EXC_LO] <= exc_code;
        if (!exl) cause_q[CA_BD] <= bus.exc_in_ds_i;
      end
    end
  end

  // EPC: first-level events record the restart PC, backing up over a branch for delay slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= '0;
    end else begin
      if (wr_epc) epc_q <= bus.wdata_i;
      if (take && !exl) epc_q <= bus.exc_in_ds_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
    end
  end

  // Redirect register: one-cycle flush toward the vector or back to EPC.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      flush_q <= take || bus.eret_i;
      if (take)             new_pc_q <= EXC_VECTOR;
      else if (bus.eret_i)  new_pc_q <= epc_q;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q;
  logic        unused_spare;
  assign unused_spare = bus.exc_req_i[7];

  // Capture the faulting address on any taken address error, nested or not.
  always_ff @(posedge clk) begin
    if (rst) badvaddr_q <= '0;
    else if (take && ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES))) badvaddr_q <= bus.exc_vaddr_i;
  end
  assign badvaddr_rd = badvaddr_q;
`else
  logic unused_vaddr;
  assign unused_vaddr = (^bus.exc_vaddr_i) ^ bus.exc_req_i[7];
  assign badvaddr_rd  = '0;
`endif

  // Combinational MFC0 read mux; compare registers are matched per present timer.
  always_comb begin
    bus.rdata_o = '0;
    if (!rst) begin
      case (bus.raddr_i)
        CP0_BADVADDR: bus.rdata_o = badvaddr_rd;
        CP0_COUNT:    bus.rdata_o = count_q;
        CP0_STATUS:   bus.rdata_o = status_q;
        CP0_CAUSE:    bus.rdata_o = cause_q;
        CP0_EPC:      bus.rdata_o = epc_q;
        CP0_PRID:     bus.rdata_o = PRID_VAL;
        CP0_CONFIG:   bus.rdata_o = CONFIG_VAL;
        default:      bus.rdata_o = '0;
      endcase
      for (int k = 0; k < NUM_TIMERS; k++)
        if (bus.raddr_i == compare_addr(k)) bus.rdata_o = compare_val[k];
    end
  end

  assign bus.flush_o  = flush_q;
  assign bus.new_pc_o = new_pc_q;
  assign status_o     = status_q;
  assign cause_o      = cause_q;
  assign epc_o        = epc_q;

endmodule

// File: tb/tb_cp0_ctrl_param.sv
// Directed bench for cp0_ctrl_param: register access table plus hand-written
// sequences for timer, priority, delay slot, nesting, ERET and BadVAddr.
module tb_cp0_ctrl_param;

  logic       clk;
  logic       rst;
  logic [5:0] hw_int;
  logic [0:0] timer_int;
  logic [31:0] status, cause, epc;

  int n_cmp  = 0;
  int n_fail = 0;

  cp0_ctrl_param_if bus ();

  cp0_ctrl_param dut (
    .clk         (clk),
    .rst         (rst),
    .hw_int_i    (hw_int),
    .bus         (bus),
    .timer_int_o (timer_int),
    .status_o    (status),
    .cause_o     (cause),
    .epc_o       (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    bus.we_i    = v.we;
    bus.waddr_i = v.waddr;
    bus.wdata_i = v.wdata;
    tick();
    bus.we_i    = 1'b0;
    bus.raddr_i = v.raddr;
    #1;
    checkOutput($sformatf("vec%0d", idx), bus.rdata_o, v.exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.we_i    = 1'b1;
    bus.waddr_i = addr;
    bus.wdata_i = data;
    tick();
    bus.we_i    = 1'b0;
  endtask

  task automatic clearEvent();
    bus.exc_req_i   = 8'h00;
    bus.eret_i      = 1'b0;
    bus.exc_pc_i    = 32'h0;
    bus.exc_in_ds_i = 1'b0;
    bus.exc_vaddr_i = 32'h0;
    bus.we_i        = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_bv;

    vecs[0]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'hF000_FF03};
    vecs[1]  = '{1'b1, 5'd12, 32'h1000_0000, 5'd12, 32'h1000_0000};
    vecs[2]  = '{1'b1, 5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
    vecs[3]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h00C0_0300};
    vecs[4]  = '{1'b1, 5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
    vecs[5]  = '{1'b1, 5'd11, 32'h0000_ABCD, 5'd11, 32'h0000_ABCD};
    vecs[6]  = '{1'b1, 5'd22, 32'h0000_0005, 5'd22, 32'h0000_0000};
    vecs[7]  = '{1'b1, 5'd8,  32'h0000_FFFF, 5'd8,  32'h0000_0000};
    vecs[8]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd15, 32'h0000_4220};
    vecs[9]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd16, 32'h0000_8000};
    vecs[10] = '{1'b1, 5'd9,  32'h0000_0064, 5'd9,  32'h0000_0064};
    vecs[11] = '{1'b0, 5'd0,  32'h0000_0000, 5'd7,  32'h0000_0000};

    rst    = 1'b1;
    hw_int = '0;
    bus.raddr_i = 5'd16;
    bus.waddr_i = 5'd0;
    bus.wdata_i = 32'h0;
    clearEvent();

    $display("[TB] reset");
    tick();
    checkOutput("rdata_in_reset", bus.rdata_o, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("status_reset", status, 32'h1000_0000);
    checkOutput("cause_reset", cause, 32'h0);
    checkOutput("epc_reset", epc, 32'h0);
    checkOutput("flush_reset", {31'h0, bus.flush_o}, 32'h0);
    checkOutput("timer_reset", {31'h0, timer_int}, 32'h0);
    checkOutput("config_read", bus.rdata_o, 32'h0000_8000);

    $display("[TB] register table");
    for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);

    $display("[TB] count wrap");
    mtc0(5'd9, 32'hFFFF_FFFF);
    bus.raddr_i = 5'd9;
    #1;
    checkOutput("count_max", bus.rdata_o, 32'hFFFF_FFFF);
    tick();
    checkOutput("count_wrap", bus.rdata_o, 32'h0);

    $display("[TB] timer");
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd0);
    repeat (20) tick();
    checkOutput("count_at_20", bus.rdata_o, 32'd20);
    checkOutput("timer_before", {31'h0, timer_int}, 32'h0);
    tick();
    checkOutput("timer_set", {31'h0, timer_int}, 32'h1);
    tick();
    checkOutput("cause_ip7", {31'h0, cause[15]}, 32'h1);

    $display("[TB] interrupt priority");
    mtc0(5'd12, 32'h1000_8001);
    bus.exc_req_i = 8'h24;
    bus.exc_pc_i  = 32'h0000_0200;
    tick();
    clearEvent();
    checkOutput("int_flush", {31'h0, bus.flush_o}, 32'h1);
    checkOutput("int_newpc", bus.new_pc_o, 32'h0000_0020);
    checkOutput("int_epc", epc, 32'h0000_0200);
    checkOutput("int_exccode", {27'h0, cause[6:2]}, 32'h0);
    checkOutput("int_exl", {31'h0, status[1]}, 32'h1);
    tick();
    checkOutput("flush_pulse", {31'h0, bus.flush_o}, 32'h0);

    mtc0(5'd11, 32'd1000);
    checkOutput("timer_clear", {31'h0, timer_int}, 32'h0);
    mtc0(5'd12, 32'h1000_0000);

    $display("[TB] delay slot");
    bus.exc_req_i   = 8'h04;
    bus.exc_pc_i    = 32'h0000_0104;
    bus.exc_in_ds_i = 1'b1;
    tick();
    clearEvent();
    checkOutput("ds_epc", epc, 32'h0000_0100);
    checkOutput("ds_bd", {31'h0, cause[31]}, 32'h1);
    checkOutput("ds_exccode", {27'h0, cause[6:2]}, 32'd8);
    checkOutput("ds_newpc", bus.new_pc_o, 32'h0000_0020);

    $display("[TB] nested");
    bus.exc_req_i = 8'h10;
    bus.exc_pc_i  = 32'h0000_0300;
    tick();
    clearEvent();
    checkOutput("nest_epc", epc, 32'h0000_0100);
    checkOutput("nest_exccode", {27'h0, cause[6:2]}, 32'd10);
    checkOutput("nest_bd", {31'h0, cause[31]}, 32'h1);

    bus.eret_i = 1'b1;
    tick();
    clearEvent();
    checkOutput("eret_exl", {31'h0, status[1]}, 32'h0);
    checkOutput("eret_flush", {31'h0, bus.flush_o}, 32'h1);
    checkOutput("eret_newpc", bus.new_pc_o, 32'h0000_0100);

    $display("[TB] event over eret and mtc0");
    bus.exc_req_i = 8'h20;
    bus.eret_i    = 1'b1;
    bus.exc_pc_i  = 32'h0000_0500;
    bus.we_i      = 1'b1;
    bus.waddr_i   = 5'd14;
    bus.wdata_i   = 32'hDEAD_BEEF;
    tick();
    clearEvent();
    checkOutput("ov_exccode", {27'h0, cause[6:2]}, 32'd12);
    checkOutput("ov_exl", {31'h0, status[1]}, 32'h1);
    checkOutput("ov_newpc", bus.new_pc_o, 32'h0000_0020);
    checkOutput("ov_epc", epc, 32'h0000_0500);

    $display("[TB] badvaddr");
    bus.exc_req_i   = 8'h01;
    bus.exc_pc_i    = 32'h0000_0600;
    bus.exc_vaddr_i = 32'h0000_1003;
    tick();
    clearEvent();
    bus.raddr_i = 5'd8;
    #1;
`ifdef CP0_BADVADDR_EN
    exp_bv = 32'h0000_1003;
`else
    exp_bv = 32'h0000_0000;
`endif
    checkOutput("badvaddr", bus.rdata_o, exp_bv);
    checkOutput("adel_exccode", {27'h0, cause[6:2]}, 32'd4);
    checkOutput("adel_epc_kept", epc, 32'h0000_0500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
